occupancy_port_arbiter: RTL and testbench
=========================================

# occupancy_port_arbiter

Single-port owner of the occupancy grid RAM, shared between three requesters: the clear sweep, the log-odds update stream from the Bresenham ray tracer, and the scan-matcher read port. Updates are performed as saturating read-modify-write sequences, so requesters never see the RAM directly. Sits between the grid update pipeline, the scan matcher and the grid RAM (1-cycle synchronous read latency).

## Interface
- ADDR_W, 16, grid cell address width; grid holds 2^ADDR_W cells
- CELL_W, 8, signed log-odds cell width
- STARVE_MAX, 8, consecutive update grants after which a waiting read wins (guard builds only)
- clock  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- clear_req  in  1  pulse; request zeroing of whole grid
- clear_busy  out  1  high while the clear sweep runs
- upd_valid  in  1  update request pending
- upd_ready  out  1  update accepted this cycle
- upd_addr  in  ADDR_W  cell to update
- upd_delta  in  CELL_W  signed log-odds increment
- rd_valid  in  1  read request pending
- rd_ready  out  1  read accepted this cycle
- rd_addr  in  ADDR_W  cell to read
- rd_data_valid  out  1  rd_data valid (one cycle after rd_ready)
- rd_data  out  CELL_W  cell value
- mem_addr  out  ADDR_W  RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  CELL_W  RAM write data
- mem_rdata  in  CELL_W  RAM read data, valid cycle after address
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, CLEAR, UPD_WR.
- clear_req in any state sets clear_pending; serviced on next cycle in IDLE.
- IDLE grant priority: clear_pending > update > read (guard may swap update/read, see Configuration). At most one grant per cycle; upd_ready/rd_ready only asserted with their valid.
- Clear grant: counter reset to 0, go CLEAR, clear_pending cleared. CLEAR writes 0 to mem_addr=counter each cycle, counter increments; on counter = 2^ADDR_W-1 write last cell, return IDLE. No upd/rd grants during CLEAR.
- Update grant (IDLE): upd_ready=1, mem_addr=upd_addr, mem_we=0; latch addr and delta; go UPD_WR. UPD_WR: mem_wdata = sat(mem_rdata + delta), mem_we=1, mem_addr=latched addr; return IDLE.
- Saturation: sum computed in CELL_W+1 bits, clamped to [-2^(CELL_W-1), 2^(CELL_W-1)-1].
- Read grant (IDLE): rd_ready=1, mem_addr=rd_addr, mem_we=0; state stays IDLE; next cycle rd_data_valid=1, rd_data=mem_rdata. Back-to-back reads allowed, one per cycle.
- Same-address consecutive updates need no forwarding: write in UPD_WR precedes next read.
- Idle mem outputs: mem_we=0, mem_addr holds last value, mem_wdata=0.

## Timing
- Reset: state IDLE, clear_pending 0, counter 0, starvation count 0; all outputs 0 (mem_addr 0, rd_data 0).
- Update: 2 cycles (grant/read, write); max throughput 1 per 2 cycles.
- Read: data 1 cycle after rd_ready; throughput 1 per cycle.
- Clear: exactly 2^ADDR_W cycles in CLEAR; clear_busy high for those cycles; grant cycle in IDLE is the cycle before.
- clear_req arriving during UPD_WR: write completes, CLEAR entered via IDLE next cycle.
- Repeated clear_req during CLEAR: sets clear_pending again; second sweep follows.
- Reset mid-CLEAR or mid-UPD_WR: abort immediately, no write in reset cycle, grid contents undefined.

## Configuration
- OCC_ARB_STARVE_GUARD_EN defined: counter of consecutive update grants while rd_valid high; at STARVE_MAX, next IDLE grant goes to read, counter clears on any read grant or rd_valid low.
- Undefined: fixed priority clear > update > read; reads may starve indefinitely.

## Structure
- occupancy_pkg: state enum, cell_t (signed CELL_W) typedef, CELL_MAX/CELL_MIN constants.
- Sub-module occupancy_sat_add: combinational saturating signed adder, used in UPD_WR.

## Test plan
- Reset, then upd addr 5 delta +3 on cell=10 -> upd_ready cycle 0, mem_we with wdata 13 cycle 1.
- Cell=120, delta +20 -> wdata 127; cell=-120, delta -20 -> wdata -128.
- ADDR_W=4, clear_req -> 16 consecutive zero writes, addrs 0..15, clear_busy 16 cycles, then IDLE.
- upd_valid and rd_valid both held high, guard on, STARVE_MAX=2 -> grants upd, upd, rd, repeating; guard off -> read never granted.
- Read addr 7 holding -4 -> rd_ready, next cycle rd_data_valid=1, rd_data=-4; two back-to-back reads in consecutive cycles.
- Reset asserted mid-CLEAR at addr 6 -> no further writes, busy 0, next clear restarts at addr 0.

Source files
------------

// File: rtl/occupancy_pkg.sv
// Shared types and constants for the occupancy grid port arbiter.
package occupancy_pkg;

  localparam int unsigned CELL_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_UPD_WR
  } state_t;

  typedef logic signed [CELL_W_DEF-1:0] cell_t;

  localparam cell_t CELL_MAX = {1'b0, {(CELL_W_DEF-1){1'b1}}};
  localparam cell_t CELL_MIN = {1'b1, {(CELL_W_DEF-1){1'b0}}};

endpackage

// File: rtl/occupancy_sat_add.sv
// Combinational saturating signed adder for log-odds cell updates.
module occupancy_sat_add
  import occupancy_pkg::*;
#(
  parameter int unsigned W = CELL_W_DEF
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] sum
);

  localparam logic signed [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

  logic signed [W:0] wide;

  // Overflow shows up as disagreement between the two top bits of the wide sum.
  always_comb begin
    wide = {a[W-1], a} + {b[W-1], b};
    if (wide[W] != wide[W-1]) begin
      sum = wide[W] ? MINV : MAXV;
    end else begin
      sum = wide[W-1:0];
    end
  end

endmodule

// File: rtl/occupancy_port_arbiter.sv
// Single-port occupancy grid RAM owner: clear sweep, saturating RMW updates, reads.
// Optional read starvation guard enabled by defining OCC_ARB_STARVE_GUARD_EN.
module occupancy_port_arbiter
  import occupancy_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned CELL_W = CELL_W_DEF
`ifdef OCC_ARB_STARVE_GUARD_EN
  ,
  parameter int unsigned STARVE_MAX = 8
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear_req,
  output logic              clear_busy,
  input  logic              upd_valid,
  output logic              upd_ready,
  input  logic [ADDR_W-1:0] upd_addr,
  input  logic [CELL_W-1:0] upd_delta,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_data_valid,
  output logic [CELL_W-1:0] rd_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [CELL_W-1:0] mem_wdata,
  input  logic [CELL_W-1:0] mem_rdata,
  output logic              busy
);

  state_t            state;
  logic              clear_pending;
  logic [ADDR_W-1:0] counter;
  logic [ADDR_W-1:0] last_addr;
  logic [ADDR_W-1:0] upd_addr_q;
  logic [CELL_W-1:0] upd_delta_q;
  logic [CELL_W-1:0] sat_sum;
  logic              read_first;
  logic              idle_free;
  logic              grant_clear;
  logic              grant_upd;
  logic              grant_rd;

  occupancy_sat_add #(.W(CELL_W)) u_sat_add (
    .a   (mem_rdata),
    .b   (upd_delta_q),
    .sum (sat_sum)
  );

  // One grant per IDLE cycle; nothing is granted while reset is asserted.
  assign idle_free   = (state == ST_IDLE) && !clear_pending && !reset;
  assign grant_clear = (state == ST_IDLE) && clear_pending && !reset;
  assign grant_upd   = idle_free && upd_valid && !(read_first && rd_valid);
  assign grant_rd    = idle_free && rd_valid && (!upd_valid || read_first);

  assign upd_ready  = grant_upd;
  assign rd_ready   = grant_rd;
  assign clear_busy = (state == ST_CLEAR);
  assign busy       = (state != ST_IDLE);
  assign rd_data    = rd_data_valid ? mem_rdata : '0;

`ifdef OCC_ARB_STARVE_GUARD_EN
  localparam int unsigned SC_W = $clog2(STARVE_MAX + 1);

  logic [SC_W-1:0] starve_cnt;

  assign read_first = (starve_cnt >= SC_W'(STARVE_MAX));

  // Consecutive update wins while a read waits; any read grant or idle read port resets it.
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!rd_valid || grant_rd) begin
      starve_cnt <= '0;
    end else if (grant_upd && !read_first) begin
      starve_cnt <= starve_cnt + SC_W'(1);
    end
  end
`else
  assign read_first = 1'b0;
`endif

  // RAM port mux; writes are suppressed in a reset cycle so aborts never land.
  always_comb begin
    mem_addr  = last_addr;
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (state)
      ST_IDLE: begin
        if (grant_upd) begin
          mem_addr = upd_addr;
        end else if (grant_rd) begin
          mem_addr = rd_addr;
        end
      end
      ST_CLEAR: begin
        mem_addr = counter;
        mem_we   = !reset;
      end
      ST_UPD_WR: begin
        mem_addr  = upd_addr_q;
        mem_we    = !reset;
        mem_wdata = sat_sum;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_IDLE;
      clear_pending <= 1'b0;
      counter       <= '0;
      last_addr     <= '0;
      upd_addr_q    <= '0;
      upd_delta_q   <= '0;
      rd_data_valid <= 1'b0;
    end else begin
      last_addr     <= mem_addr;
      rd_data_valid <= grant_rd;
      // A new request in the grant cycle re-arms the pending flag for a second sweep.
      if (grant_clear) clear_pending <= 1'b0;
      if (clear_req)   clear_pending <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (grant_clear) begin
            counter <= '0;
            state   <= ST_CLEAR;
          end else if (grant_upd) begin
            upd_addr_q  <= upd_addr;
            upd_delta_q <= upd_delta;
            state       <= ST_UPD_WR;
          end
        end
        ST_CLEAR: begin
          counter <= counter + ADDR_W'(1);
          if (counter == '1) state <= ST_IDLE;
        end
        ST_UPD_WR: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_occupancy_port_arbiter.sv
// Directed self-checking bench for occupancy_port_arbiter with a small grid RAM model.
module tb_occupancy_port_arbiter;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned CELL_W = 8;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              clear_req = 1'b0;
  logic              clear_busy;
  logic              upd_valid = 1'b0;
  logic              upd_ready;
  logic [ADDR_W-1:0] upd_addr = '0;
  logic [CELL_W-1:0] upd_delta = '0;
  logic              rd_valid = 1'b0;
  logic              rd_ready;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic              rd_data_valid;
  logic [CELL_W-1:0] rd_data;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [CELL_W-1:0] mem_wdata;
  logic [CELL_W-1:0] mem_rdata;
  logic              busy;

  logic              pl_en = 1'b0;
  logic [ADDR_W-1:0] pl_addr = '0;
  logic [CELL_W-1:0] pl_data = '0;
  logic [CELL_W-1:0] ram [2**ADDR_W];

  int checks = 0;
  int errors = 0;

  logic [9:0] exp_u;
  logic [9:0] exp_r;

  occupancy_port_arbiter #(
    .ADDR_W(ADDR_W),
    .CELL_W(CELL_W)
`ifdef OCC_ARB_STARVE_GUARD_EN
    ,
    .STARVE_MAX(2)
`endif
  ) dut (
    .clock(clock),
    .reset(reset),
    .clear_req(clear_req),
    .clear_busy(clear_busy),
    .upd_valid(upd_valid),
    .upd_ready(upd_ready),
    .upd_addr(upd_addr),
    .upd_delta(upd_delta),
    .rd_valid(rd_valid),
    .rd_ready(rd_ready),
    .rd_addr(rd_addr),
    .rd_data_valid(rd_data_valid),
    .rd_data(rd_data),
    .mem_addr(mem_addr),
    .mem_we(mem_we),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clock = ~clock;

  // Synchronous RAM, one-cycle read latency, with a bench-side preload port.
  always @(posedge clock) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_mem(input string tag, input logic we, input logic [ADDR_W-1:0] a,
                         input logic [CELL_W-1:0] d);
    chk({tag, "_we"}, 32'(mem_we), 32'(we));
    chk({tag, "_addr"}, 32'(mem_addr), 32'(a));
    chk({tag, "_wdata"}, 32'(mem_wdata), 32'(d));
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [CELL_W-1:0] d);
    @(negedge clock);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clock);
    pl_en = 1'b0;
  endtask

  task automatic do_upd(input string tag, input logic [ADDR_W-1:0] a,
                        input logic [CELL_W-1:0] d, input logic [CELL_W-1:0] exp);
    @(negedge clock);
    upd_valid = 1'b1; upd_addr = a; upd_delta = d;
    #1;
    chk({tag, "_ready"}, 32'(upd_ready), 32'd1);
    chk_mem({tag, "_grant"}, 1'b0, a, '0);
    @(negedge clock);
    upd_valid = 1'b0;
    #1;
    chk_mem({tag, "_write"}, 1'b1, a, exp);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    @(negedge clock);
    #1;
    chk_mem({tag, "_idle"}, 1'b0, a, '0);
    chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_clear_busy", 32'(clear_busy), 32'd0);
    chk("rst_rd_valid", 32'(rd_data_valid), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_upd_ready", 32'(upd_ready), 32'd0);
    chk("rst_rd_ready", 32'(rd_ready), 32'd0);
    chk_mem("rst_mem", 1'b0, 4'd0, 8'd0);

    preload(4'd5, 8'd10);
    preload(4'd3, 8'd120);
    preload(4'd9, 8'h88);
    preload(4'd7, 8'hFC);
    preload(4'd1, 8'd0);

    // 10+3, 120+20 saturates high, -120-20 saturates low.
    do_upd("upd_plain", 4'd5, 8'd3, 8'd13);
    do_upd("upd_sat_hi", 4'd3, 8'd20, 8'h7F);
    do_upd("upd_sat_lo", 4'd9, 8'hEC, 8'h80);

    // Back-to-back reads: addr 7 (-4) then addr 5 (13).
    @(negedge clock);
    rd_valid = 1'b1; rd_addr = 4'd7;
    #1;
    chk("rd0_ready", 32'(rd_ready), 32'd1);
    chk_mem("rd0_grant", 1'b0, 4'd7, '0);
    @(negedge clock);
    rd_addr = 4'd5;
    #1;
    chk("rd1_ready", 32'(rd_ready), 32'd1);
    chk("rd0_dvalid", 32'(rd_data_valid), 32'd1);
    chk("rd0_data", 32'(rd_data), 32'h0FC);
    @(negedge clock);
    rd_valid = 1'b0;
    #1;
    chk("rd1_dvalid", 32'(rd_data_valid), 32'd1);
    chk("rd1_data", 32'(rd_data), 32'd13);
    @(negedge clock);
    #1;
    chk("rd_done_dvalid", 32'(rd_data_valid), 32'd0);

    // Both requesters held high.
`ifdef OCC_ARB_STARVE_GUARD_EN
    exp_u = 10'b0010100101;
    exp_r = 10'b1000010000;
`else
    exp_u = 10'b0101010101;
    exp_r = 10'b0000000000;
`endif
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (i == 0) begin
        upd_valid = 1'b1; upd_addr = 4'd1; upd_delta = 8'd1;
        rd_valid = 1'b1; rd_addr = 4'd2;
      end
      #1;
      chk($sformatf("arb%0d_upd", i), 32'(upd_ready), 32'(exp_u[i]));
      chk($sformatf("arb%0d_rd", i), 32'(rd_ready), 32'(exp_r[i]));
    end
    @(negedge clock);
    upd_valid = 1'b0; rd_valid = 1'b0;
    repeat (3) @(negedge clock);

    // Full clear sweep with a read waiting throughout.
    clear_req = 1'b1;
    #1;
    chk("clr_req_cb", 32'(clear_busy), 32'd0);
    @(negedge clock);
    clear_req = 1'b0; rd_valid = 1'b1; rd_addr = 4'd5;
    #1;
    chk("clr_grant_cb", 32'(clear_busy), 32'd0);
    chk("clr_grant_rd", 32'(rd_ready), 32'd0);
    chk("clr_grant_we", 32'(mem_we), 32'd0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      #1;
      chk($sformatf("clr%0d_cb", i), 32'(clear_busy), 32'd1);
      chk($sformatf("clr%0d_rd", i), 32'(rd_ready), 32'd0);
      chk_mem($sformatf("clr%0d", i), 1'b1, 4'(i), 8'd0);
    end
    @(negedge clock);
    #1;
    chk("clr_end_cb", 32'(clear_busy), 32'd0);
    chk("clr_end_busy", 32'(busy), 32'd0);
    chk("clr_end_rd", 32'(rd_ready), 32'd1);
    chk_mem("clr_end", 1'b0, 4'd5, 8'd0);
    @(negedge clock);
    rd_valid = 1'b0;
    #1;
    chk("clr_rd_dvalid", 32'(rd_data_valid), 32'd1);
    chk("clr_rd_data", 32'(rd_data), 32'd0);

    // Clear request during UPD_WR, then reset mid-sweep at addr 6.
    @(negedge clock);
    upd_valid = 1'b1; upd_addr = 4'd5; upd_delta = 8'd1;
    #1;
    chk("uc_ready", 32'(upd_ready), 32'd1);
    @(negedge clock);
    upd_valid = 1'b0; clear_req = 1'b1;
    #1;
    chk_mem("uc_write", 1'b1, 4'd5, 8'd1);
    @(negedge clock);
    clear_req = 1'b0;
    #1;
    chk("uc_grant_busy", 32'(busy), 32'd0);
    chk("uc_grant_we", 32'(mem_we), 32'd0);
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      if (i == 6) reset = 1'b1;
      #1;
      if (i < 6) chk_mem($sformatf("uc_clr%0d", i), 1'b1, 4'(i), 8'd0);
      else chk("uc_rst_we", 32'(mem_we), 32'd0);
    end
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_cb", 32'(clear_busy), 32'd0);
    chk_mem("ab_mem", 1'b0, 4'd0, 8'd0);

    // Sweep after abort restarts at address 0 and lasts 16 cycles.
    @(negedge clock);
    clear_req = 1'b1;
    @(negedge clock);
    clear_req = 1'b0;
    @(negedge clock);
    #1;
    chk("re_cb", 32'(clear_busy), 32'd1);
    chk_mem("re_first", 1'b1, 4'd0, 8'd0);
    repeat (15) @(negedge clock);
    #1;
    chk_mem("re_last", 1'b1, 4'd15, 8'd0);
    @(negedge clock);
    #1;
    chk("re_end_busy", 32'(busy), 32'd0);
    chk("re_end_we", 32'(mem_we), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
